lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
Receive-side companion to the 26-bit Galois LFSR pattern generator. It takes the generator's parallel state word each valid cycle and seeds itself from the incoming stream. It confirms lock after a run of correct predictions, then flywheels and counts mismatches. It sits at the far end of the test link and reports lock status and bit-stream integrity.

Parameters:
N, 26, LFSR width; data_in and expected width
TAP_MASK, 26'h0000046, Galois tap positions (bits 1, 2, 6); polynomial x^26+x^6+x^2+x+1
LOCK_MATCHES, 4, consecutive correct words needed to declare lock (min 1)
UNLOCK_MISSES, 3, consecutive mismatches in LOCKED that drop lock (min 1)
CW, 16, error counter width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
data_in  input  N  received LFSR state word
valid_in  input  1  data_in is valid this cycle
resync  input  1  synchronous request to drop lock and re-hunt
locked  output  1  registered; high while in LOCKED
mismatch  output  1  registered one-cycle pulse; LOCKED-state word differed from prediction
err_count  output  CW  registered saturating count of LOCKED mismatches
expected  output  N  registered prediction for the next valid word

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state = HUNT, locked = 0, mismatch = 0, err_count = 0, expected = 0, match_cnt = 0, miss_cnt = 0.
- next(x) function:
  - nx[0] = x[N-1].
  - For i >= 1: nx[i] = x[i-1] ^ (TAP_MASK[i] & x[N-1]).
  - TAP_MASK[0] is ignored.
- Only cycles with valid_in = 1 advance the state; idle cycles hold all registers. mismatch = 0 on idle cycles.
- HUNT:
  - If valid_in is high and data_in != 0, then expected <= next(data_in) and match_cnt <= 0.
  - Go to VERIFY, or go directly to LOCKED if LOCK_MATCHES == 1.
  - An all-zero word is the lockup state and is not a legal seed: ignore it and stay in HUNT.
- VERIFY:
  - On a valid word equal to expected: match_cnt++ and expected <= next(expected).
  - When the incremented match_cnt reaches LOCK_MATCHES - 1, go to LOCKED. locked rises the cycle after that word.
  - On a mismatch: reseed from the word. If data_in != 0, then expected <= next(data_in), match_cnt <= 0, and stay in VERIFY. If data_in == 0, go to HUNT.
  - No mismatch pulse and no err_count change occur in VERIFY.
- LOCKED:
  - On every valid word, expected <= next(expected). This is flywheel operation: never reseed from the data.
  - On a match: miss_cnt <= 0.
  - On a mismatch:
    - mismatch = 1 the next cycle.
    - err_count++, saturating at 2^CW - 1 with no wrap.
    - miss_cnt++.
    - When miss_cnt reaches UNLOCK_MISSES: go to HUNT, locked <= 0, and clear miss_cnt and match_cnt. err_count is kept.
- Latency: mismatch, locked and err_count reflect a word exactly one cycle after its valid_in cycle.
- resync:
  - Forces HUNT next cycle and clears locked, mismatch, match_cnt, miss_cnt and expected. err_count is preserved.
  - resync takes precedence over a simultaneous valid word; that word is discarded.
- reset has precedence over resync and valid_in. Reset mid-operation returns everything to reset values on the next edge.
- State encoding is free. States are HUNT, VERIFY and LOCKED only.

Test Plan:
- Clean lock: reset, then stream seed 26'h0000001 followed by successive next() values 2, 4, 8, ... -> locked = 0 through the 3rd valid word; locked = 1 the cycle after the 4th word (26'h0000008); mismatch never pulses; err_count = 0.
- Tap wrap: while locked, drive 26'h2000000 then 26'h0000047 -> no mismatch, because next(26'h2000000) = 26'h0000047; expected = next(26'h0000047) afterwards.
- Single error: in LOCKED, flip bit 0 of one word -> one-cycle mismatch pulse, err_count = 1, locked stays 1; the following correct words give no further pulses, and expected stays on the true sequence (flywheel).
- Loss of lock: 3 consecutive corrupted words in LOCKED -> err_count += 3, locked falls the cycle after the 3rd; a fresh seed 26'h0000001 plus 3 correct words relocks; err_count unchanged during relock.
- Zero seed and VERIFY reseed: in HUNT send 26'h0000000 -> stays HUNT. Then send 1, 2, 5 (a bad prediction), 26'h000000A, 26'h0000014, 26'h0000028 -> reseed at 5 and lock after 26'h0000028; err_count = 0.
- Precedence: assert resync together with valid_in while LOCKED -> locked = 0 next cycle, word ignored, err_count held. Assert reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for a 26-bit Galois LFSR stream.
// It seeds from the incoming state words and confirms lock after a run of
// correct predictions. Once locked it flywheels on its own prediction and
// counts mismatched words in a saturating error counter.
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | waiting for a non-zero word to seed the prediction
// VERIFY | seeded; counting consecutive correct predictions toward lock
// LOCKED | flywheeling; mismatches are flagged, counted, may drop lock
module lfsr_checker #(
  parameter int           N             = 26,
  parameter logic [N-1:0] TAP_MASK      = 26'h0000046,
  parameter int           LOCK_MATCHES  = 4,
  parameter int           UNLOCK_MISSES = 3,
  parameter int           CW            = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  data_in,
  input  logic          valid_in,
  input  logic          resync,
  output logic          locked,
  output logic          mismatch,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  expected
);

  // Counter widths are sized so the terminal values are representable.
  localparam int MW  = $clog2(LOCK_MATCHES + 1);
  localparam int MSW = $clog2(UNLOCK_MISSES + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   match_q, match_d, match_inc;
  logic [MSW-1:0]  miss_q, miss_d, miss_inc;
  logic [N-1:0]    expected_d;
  logic [CW-1:0]   err_d;
  logic            mismatch_d;
  logic            locked_d;
  logic            word_ok;

  // One Galois step: shift left, the old MSB re-enters at bit 0 and is
  // XORed into every tap position above bit 0.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
    logic [N-1:0] taps;
    taps = {TAP_MASK[N-1:1], 1'b0};
    return {x[N-2:0], x[N-1]} ^ (taps & {N{x[N-1]}});
  endfunction

  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + MSW'(1);
  assign word_ok   = (data_in == expected);

  // Next-state and next-output logic; idle cycles hold everything and
  // keep the mismatch pulse low.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    miss_d     = miss_q;
    expected_d = expected;
    err_d      = err_count;
    mismatch_d = 1'b0;

    if (resync) begin
      // A word arriving with resync is discarded.
      state_d    = HUNT;
      match_d    = '0;
      miss_d     = '0;
      expected_d = '0;
    end else if (valid_in) begin
      unique case (state_q)
        HUNT: begin
          // All-zero is the LFSR lockup state and can never seed.
          if (data_in != '0) begin
            expected_d = lfsr_next(data_in);
            match_d    = '0;
            state_d    = (LOCK_MATCHES == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (word_ok) begin
            match_d    = match_inc;
            expected_d = lfsr_next(expected);
            if (match_inc == MW'(LOCK_MATCHES - 1)) begin
              state_d = LOCKED;
            end
          end else if (data_in != '0) begin
            expected_d = lfsr_next(data_in);
            match_d    = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never follows the received data here.
          expected_d = lfsr_next(expected);
          if (word_ok) begin
            miss_d = '0;
          end else begin
            mismatch_d = 1'b1;
            if (err_count != {CW{1'b1}}) begin
              err_d = err_count + CW'(1);
            end
            if (miss_inc == MSW'(UNLOCK_MISSES)) begin
              state_d = HUNT;
              miss_d  = '0;
              match_d = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      match_q   <= '0;
      miss_q    <= '0;
      expected  <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      expected  <= expected_d;
      err_count <= err_d;
      mismatch  <= mismatch_d;
      locked    <= locked_d;
    end
  end

endmodule
